// File: rtl/cv32e40p_cg_pkg.sv
// Shared types and helpers for the automatic clock-gating controller.
// Imported by the per-channel FSM and the top-level controller.
package cv32e40p_cg_pkg;

   typedef enum logic [1:0] {
      CG_ON    = 2'd0,
      CG_COUNT = 2'd1,
      CG_OFF   = 2'd2,
      CG_WAKE  = 2'd3
   } cg_state_e;

   localparam int unsigned WAKE_CYCLES_DFLT = 2;

   // Wake counter must hold 0..WAKE_CYCLES-1 for any channel configuration.
   function automatic int unsigned wake_width(input int unsigned wake_cycles);
      return (wake_cycles < 2) ? 1 : $clog2(wake_cycles + 1);
   endfunction

   localparam int unsigned WAKE_W = wake_width(WAKE_CYCLES_DFLT);

endpackage

// File: rtl/cv32e40p_cg_chan.sv
// One gating channel: idle counter, wake warm-up counter and the 4-state FSM.
// The enable is registered so the gate cell always sees a clean flop output.
module cv32e40p_cg_chan
   import cv32e40p_cg_pkg::*;
#(
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned WAKE_CYCLES = WAKE_CYCLES_DFLT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             force_on,
   input  logic [CNT_W-1:0] idle_thresh,
   input  logic             busy,
   input  logic             wake_req,
   output logic             en,
   output logic             gated,
   output logic             wake_ack
);

   localparam int unsigned WCW = wake_width(WAKE_CYCLES);
   localparam logic [WCW-1:0] WAKE_LAST = WCW'(WAKE_CYCLES - 1);

   cg_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WCW-1:0]   wcnt_q, wcnt_d;
   logic             en_q;
   logic             active;
   logic [CNT_W:0]   cnt_inc;

   assign active  = busy | wake_req | force_on;
   // One bit wider than the counter so the threshold compare never sees a wrap.
   assign cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CG_ON;
         cnt_q   <= '0;
         wcnt_q  <= '0;
         en_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
         en_q    <= (state_d != CG_OFF);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      unique case (state_q)
         CG_ON: begin
            cnt_d = '0;
            if (!active && idle_thresh == CNT_W'(1)) begin
               state_d = CG_OFF;
            end else if (!active && idle_thresh > CNT_W'(1)) begin
               state_d = CG_COUNT;
               cnt_d   = CNT_W'(1);
            end
         end
         CG_COUNT: begin
            if (active || idle_thresh == '0) begin
               state_d = CG_ON;
               cnt_d   = '0;
            end else if (cnt_inc >= {1'b0, idle_thresh}) begin
               state_d = CG_OFF;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc[CNT_W-1:0];
            end
         end
         CG_OFF: begin
            if (active) begin
               state_d = CG_WAKE;
               wcnt_d  = '0;
            end
         end
         CG_WAKE: begin
            // Inputs are ignored here: once started, a wake always completes.
            if (wcnt_q == WAKE_LAST) begin
               state_d = CG_ON;
               wcnt_d  = '0;
            end else begin
               wcnt_d = wcnt_q + WCW'(1);
            end
         end
         default: state_d = CG_ON;
      endcase
   end

   assign en       = en_q;
   assign gated    = (state_q == CG_OFF);
   assign wake_ack = wake_req & ((state_q == CG_ON) | (state_q == CG_COUNT));

endmodule

// File: rtl/cv32e40p_clock_gate.sv
// Latch-based glitch-free clock gate: enable is captured only while clk_i is low.
// scan_cg_en_i forces the gate open regardless of the functional enable.
module cv32e40p_clock_gate (
   input  logic clk_i,
   input  logic en_i,
   input  logic scan_cg_en_i,
   output logic clk_o
);

   logic en_latch;

   always_latch begin
      if (!clk_i) begin
         en_latch = en_i | scan_cg_en_i;
      end
   end

   assign clk_o = clk_i & en_latch;

endmodule

// File: rtl/cv32e40p_clock_gate_ctrl.sv
// Multi-channel automatic clock-gating controller: one FSM plus one gate cell
// per channel, sharing force_on_i, scan_cg_en_i and the idle threshold.
module cv32e40p_clock_gate_ctrl
   import cv32e40p_cg_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned WAKE_CYCLES = WAKE_CYCLES_DFLT
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              scan_cg_en_i,
   input  logic              force_on_i,
   input  logic [CNT_W-1:0]  idle_thresh_i,
   input  logic [NUM_CH-1:0] busy_i,
   input  logic [NUM_CH-1:0] wake_req_i,
   output logic [NUM_CH-1:0] wake_ack_o,
   output logic [NUM_CH-1:0] gated_o,
   output logic [NUM_CH-1:0] clk_o
);

   logic [NUM_CH-1:0] en;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      cv32e40p_cg_chan #(
         .CNT_W       (CNT_W),
         .WAKE_CYCLES (WAKE_CYCLES)
      ) u_chan (
         .clk         (clk_i),
         .rst_n       (rst_ni),
         .force_on    (force_on_i),
         .idle_thresh (idle_thresh_i),
         .busy        (busy_i[g]),
         .wake_req    (wake_req_i[g]),
         .en          (en[g]),
         .gated       (gated_o[g]),
         .wake_ack    (wake_ack_o[g])
      );

      cv32e40p_clock_gate u_gate (
         .clk_i        (clk_i),
         .en_i         (en[g]),
         .scan_cg_en_i (scan_cg_en_i),
         .clk_o        (clk_o[g])
      );
   end

endmodule

// File: tb/tb_cv32e40p_clock_gate_ctrl.sv
// Directed bench for the clock-gating controller: expectations are queued as
// stimulus is applied and popped/compared once the DUT has had its edges.
module tb_cv32e40p_clock_gate_ctrl;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 8;
   localparam int WAKE_CYCLES = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              scan_cg_en = 1'b0;
   logic              force_on = 1'b0;
   logic [CNT_W-1:0]  idle_thresh = '0;
   logic [NUM_CH-1:0] busy = '0;
   logic [NUM_CH-1:0] wake_req = '0;
   logic [NUM_CH-1:0] wake_ack;
   logic [NUM_CH-1:0] gated;
   logic [NUM_CH-1:0] clk_gated;

   cv32e40p_clock_gate_ctrl #(
      .NUM_CH      (NUM_CH),
      .CNT_W       (CNT_W),
      .WAKE_CYCLES (WAKE_CYCLES)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .scan_cg_en_i  (scan_cg_en),
      .force_on_i    (force_on),
      .idle_thresh_i (idle_thresh),
      .busy_i        (busy),
      .wake_req_i    (wake_req),
      .wake_ack_o    (wake_ack),
      .gated_o       (gated),
      .clk_o         (clk_gated)
   );

   always #5 clk = ~clk;

   int edges [NUM_CH];
   for (genvar g = 0; g < NUM_CH; g++) begin : g_mon
      initial edges[g] = 0;
      always @(posedge clk_gated[g]) edges[g] = edges[g] + 1;
   end

   // Narrowest high pulse seen on channel 1, used to catch truncated pulses.
   time rise_t = 0;
   int  min_high = 1000;
   always @(posedge clk_gated[1]) rise_t = $time;
   always @(negedge clk_gated[1]) begin
      if (int'($time - rise_t) < min_high) min_high = int'($time - rise_t);
   end

   typedef struct {
      string       tag;
      int          kind;
      int          ch;
      logic [31:0] exp;
      int          base;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   task automatic push(input string tag, input int kind, input int ch,
                       input logic [31:0] exp, input int base);
      exp_t e;
      e.tag  = tag;
      e.kind = kind;
      e.ch   = ch;
      e.exp  = exp;
      e.base = base;
      sb.push_back(e);
   endtask

   function automatic logic [31:0] observe(input exp_t e);
      logic [31:0] v;
      v = '0;
      case (e.kind)
         0: v = 32'(gated[e.ch]);
         1: v = 32'(wake_ack[e.ch]);
         2: v = 32'(edges[e.ch] - e.base);
         3: v = 32'(gated);
         4: v = 32'(wake_ack);
         default: v = 32'(min_high);
      endcase
      return v;
   endfunction

   task automatic check_output();
      exp_t        e;
      logic [31:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e);
         n_assert++;
         assert (obs === e.exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic apply_stimulus(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int b0, b1, b2, b3;

   initial begin
      // Reset: everything on, ack follows request, clock runs through reset.
      idle_thresh = 8'd3;
      busy        = 4'b1111;
      wake_req    = 4'b0100;
      #1 rst_n = 1'b0;
      #2;
      b0 = edges[0];
      push("rst_gated", 3, 0, 32'h0, 0);
      push("rst_ack", 4, 0, 32'h4, 0);
      check_output();
      apply_stimulus(2);
      push("rst_clk_runs", 2, 0, 32'd2, b0);
      check_output();
      rst_n    = 1'b1;
      wake_req = '0;
      apply_stimulus(2);

      // Idle gating on ch0/ch1 with threshold 3.
      busy = 4'b1100;
      b0 = edges[0];
      b3 = edges[3];
      apply_stimulus(2);
      push("idle_not_yet", 3, 0, 32'h0, 0);
      check_output();
      apply_stimulus(1);
      push("idle_gated0", 0, 0, 32'h1, 0);
      push("idle_gated1", 0, 1, 32'h1, 0);
      push("idle_edges0", 2, 0, 32'd3, b0);
      check_output();
      apply_stimulus(5);
      push("idle_edges0_stop", 2, 0, 32'd3, b0);
      push("busy_edges3", 2, 3, 32'd8, b3);
      push("idle_vec", 3, 0, 32'h3, 0);
      check_output();

      // Wake ch1 with request held until acknowledged.
      wake_req[1] = 1'b1;
      b1 = edges[1];
      apply_stimulus(1);
      push("wake_ungated", 0, 1, 32'h0, 0);
      push("wake_ack_lo0", 1, 1, 32'h0, 0);
      push("wake_edges_w", 2, 1, 32'd0, b1);
      check_output();
      apply_stimulus(1);
      push("wake_ack_lo1", 1, 1, 32'h0, 0);
      push("wake_edges_w1", 2, 1, 32'd1, b1);
      check_output();
      apply_stimulus(1);
      push("wake_ack_hi", 1, 1, 32'h1, 0);
      push("wake_edges_w2", 2, 1, 32'd2, b1);
      check_output();
      wake_req[1] = 1'b0;

      // Wake ch0 with the request dropped right after it is sampled.
      wake_req[0] = 1'b1;
      apply_stimulus(1);
      wake_req[0] = 1'b0;
      b0 = edges[0];
      apply_stimulus(2);
      push("drop_wake_edges", 2, 0, 32'd2, b0);
      push("drop_vec", 3, 0, 32'h2, 0);
      check_output();
      apply_stimulus(2);
      push("drop_regate_early", 0, 0, 32'h0, 0);
      check_output();
      apply_stimulus(1);
      push("drop_regate", 3, 0, 32'h3, 0);
      check_output();

      // Busy blip on ch2 with threshold 4 restarts the idle count.
      idle_thresh = 8'd4;
      busy[2] = 1'b0;
      apply_stimulus(3);
      push("blip_pre", 0, 2, 32'h0, 0);
      check_output();
      busy[2] = 1'b1;
      apply_stimulus(1);
      busy[2] = 1'b0;
      apply_stimulus(3);
      push("blip_restart", 0, 2, 32'h0, 0);
      check_output();
      apply_stimulus(1);
      push("blip_gated", 0, 2, 32'h1, 0);
      check_output();

      // Threshold 0 disables gating; lowering it below cnt gates next edge.
      idle_thresh = 8'd0;
      busy[3] = 1'b0;
      apply_stimulus(20);
      push("thresh0_vec", 3, 0, 32'h7, 0);
      check_output();
      idle_thresh = 8'd8;
      apply_stimulus(5);
      push("thresh8_cnt5", 0, 3, 32'h0, 0);
      check_output();
      idle_thresh = 8'd3;
      apply_stimulus(1);
      push("thresh_lowered", 3, 0, 32'hF, 0);
      check_output();

      // force_on wakes every channel; ack only once back in CG_ON.
      force_on    = 1'b1;
      wake_req[3] = 1'b1;
      apply_stimulus(1);
      push("force_vec", 3, 0, 32'h0, 0);
      push("force_ack_lo", 4, 0, 32'h0, 0);
      check_output();
      apply_stimulus(1);
      push("force_ack_lo2", 4, 0, 32'h0, 0);
      check_output();
      apply_stimulus(1);
      push("force_ack_hi", 4, 0, 32'h8, 0);
      check_output();
      force_on = 1'b0;
      wake_req = '0;
      apply_stimulus(2);
      push("force_regate_early", 3, 0, 32'h0, 0);
      check_output();
      apply_stimulus(1);
      push("force_regate", 3, 0, 32'hF, 0);
      check_output();

      // Scan enable runs clocks without touching the FSM.
      scan_cg_en = 1'b1;
      b2 = edges[2];
      apply_stimulus(4);
      push("scan_edges", 2, 2, 32'd4, b2);
      push("scan_gated", 3, 0, 32'hF, 0);
      check_output();
      scan_cg_en = 1'b0;
      b2 = edges[2];
      apply_stimulus(3);
      push("scan_off_edges", 2, 2, 32'd0, b2);
      check_output();

      // Reset in the middle of a wake aborts to CG_ON immediately.
      wake_req[0] = 1'b1;
      apply_stimulus(1);
      push("prewake_vec", 3, 0, 32'hE, 0);
      check_output();
      #2 rst_n = 1'b0;
      #1;
      push("midwake_rst_vec", 3, 0, 32'h0, 0);
      push("midwake_rst_ack", 4, 0, 32'h1, 0);
      check_output();
      b1 = edges[1];
      min_high = 1000;
      #3 rst_n = 1'b1;
      wake_req = '0;
      busy     = 4'b1111;
      apply_stimulus(3);
      #4;
      push("post_rst_edges", 2, 1, 32'd3, b1);
      push("post_rst_pulse", 5, 0, 32'd5, 0);
      check_output();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
